// File: rtl/freq_meter.sv
// Frequency/period meter: counts synchronized rising edges of sig_in per gate
// window and measures clk cycles between consecutive rising edges.
module freq_meter #(
  parameter int GATE_CYCLES = 50000,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             sig_in,
  output logic [CNT_W-1:0] freq_cnt,
  output logic             freq_ovf,
  output logic             freq_valid,
  output logic [CNT_W-1:0] period_cnt,
  output logic             period_ovf,
  output logic             period_valid,
  output logic             busy
);

  localparam int GW = $clog2(GATE_CYCLES);
  localparam logic [GW-1:0]    GATE_LAST = GW'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  typedef enum logic {ST_IDLE, ST_GATE} state_t;

  state_t           state_q, state_d;
  logic             s1_q, s2_q, s3_q;
  logic             rise;
  logic [GW-1:0]    gate_q, gate_d;
  logic [CNT_W-1:0] edge_q, edge_d;
  logic             win_ovf_q, win_ovf_d;
  logic [CNT_W-1:0] freq_cnt_q, freq_cnt_d;
  logic             freq_ovf_q, freq_ovf_d;
  logic             freq_valid_q, freq_valid_d;
  logic [CNT_W-1:0] run_q, run_d;
  logic             armed_q, armed_d;
  logic [CNT_W-1:0] period_cnt_q, period_cnt_d;
  logic             period_ovf_q, period_ovf_d;
  logic             period_valid_q, period_valid_d;
  logic             busy_q, busy_d;

  // s3 is the history flop; s2 is the last synchronized sample.
  assign rise = s2_q & ~s3_q;

  always_comb begin
    state_d      = state_q;
    gate_d       = gate_q;
    edge_d       = edge_q;
    win_ovf_d    = win_ovf_q;
    freq_cnt_d   = freq_cnt_q;
    freq_ovf_d   = freq_ovf_q;
    freq_valid_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (en) begin
          state_d   = ST_GATE;
          gate_d    = '0;
          edge_d    = '0;
          win_ovf_d = 1'b0;
        end
      end
      ST_GATE: begin
        if (!en) begin
          state_d = ST_IDLE;
        end else if (gate_q == GATE_LAST) begin
          // Close the window, folding in a rise that lands on its last cycle.
          if (rise && (edge_q == CNT_MAX)) begin
            freq_cnt_d = CNT_MAX;
            freq_ovf_d = 1'b1;
          end else begin
            freq_cnt_d = edge_q + CNT_W'(rise);
            freq_ovf_d = win_ovf_q;
          end
          freq_valid_d = 1'b1;
          gate_d       = '0;
          edge_d       = '0;
          win_ovf_d    = 1'b0;
        end else begin
          gate_d = gate_q + GW'(1);
          if (rise) begin
            if (edge_q == CNT_MAX) win_ovf_d = 1'b1;
            else                   edge_d    = edge_q + CNT_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d == ST_GATE);
  end

  always_comb begin
    run_d          = run_q;
    armed_d        = armed_q;
    period_cnt_d   = period_cnt_q;
    period_ovf_d   = period_ovf_q;
    period_valid_d = 1'b0;

    if (en) begin
      if (rise) begin
        run_d   = '0;
        armed_d = 1'b1;
        if (armed_q) begin
          period_cnt_d   = (run_q == CNT_MAX) ? CNT_MAX : run_q + CNT_W'(1);
          period_ovf_d   = (run_q == CNT_MAX);
          period_valid_d = 1'b1;
        end
      end else if (run_q != CNT_MAX) begin
        run_d = run_q + CNT_W'(1);
      end
    end else begin
      run_d   = '0;
      armed_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q           <= 1'b0;
      s2_q           <= 1'b0;
      s3_q           <= 1'b0;
      state_q        <= ST_IDLE;
      gate_q         <= '0;
      edge_q         <= '0;
      win_ovf_q      <= 1'b0;
      freq_cnt_q     <= '0;
      freq_ovf_q     <= 1'b0;
      freq_valid_q   <= 1'b0;
      run_q          <= '0;
      armed_q        <= 1'b0;
      period_cnt_q   <= '0;
      period_ovf_q   <= 1'b0;
      period_valid_q <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      s1_q           <= sig_in;
      s2_q           <= s1_q;
      s3_q           <= s2_q;
      state_q        <= state_d;
      gate_q         <= gate_d;
      edge_q         <= edge_d;
      win_ovf_q      <= win_ovf_d;
      freq_cnt_q     <= freq_cnt_d;
      freq_ovf_q     <= freq_ovf_d;
      freq_valid_q   <= freq_valid_d;
      run_q          <= run_d;
      armed_q        <= armed_d;
      period_cnt_q   <= period_cnt_d;
      period_ovf_q   <= period_ovf_d;
      period_valid_q <= period_valid_d;
      busy_q         <= busy_d;
    end
  end

  assign freq_cnt     = freq_cnt_q;
  assign freq_ovf     = freq_ovf_q;
  assign freq_valid   = freq_valid_q;
  assign period_cnt   = period_cnt_q;
  assign period_ovf   = period_ovf_q;
  assign period_valid = period_valid_q;
  assign busy         = busy_q;

endmodule

// File: doc/freq_meter.md
# freq_meter

Frequency and period meter for the divided-clock outputs of the frequency-divider stage. It runs on the system clock `clk` and samples a divided clock such as the 2 MHz output (`sig_in`) as an asynchronous data signal. It reports two results: rising edges counted per fixed gate window, and `clk` cycles between consecutive rising edges. It sits directly downstream of the divider and provides the on-chip check of divide ratio and stability.

## Interface
- `GATE_CYCLES`, default 50000: gate window length in `clk` cycles; must be ≥ 2.
- `CNT_W`, default 16: width of the edge counter and the period counter, including their result registers.
- `clk`  in  1  system clock; all logic is on its rising edge.
- `rst`  in  1  reset, synchronous to `clk`, active-high.
- `en`  in  1  1 = measure continuously; 0 = idle.
- `sig_in`  in  1  measured signal, asynchronous to `clk`.
- `freq_cnt`  out  CNT_W  rising edges counted in the last completed window.
- `freq_ovf`  out  1  edge count saturated in the last completed window.
- `freq_valid`  out  1  one-cycle pulse when `freq_cnt` and `freq_ovf` update.
- `period_cnt`  out  CNT_W  `clk` cycles between the last two rising edges.
- `period_ovf`  out  1  period counter saturated for the last reported period.
- `period_valid`  out  1  one-cycle pulse when `period_cnt` and `period_ovf` update.
- `busy`  out  1  high while a gate window is open.

## Operation
- **Synchronizer:** `sig_in` passes through two flops (s1, s2), then a history flop s3.
  - rise = s2 & ~s3.
  - The synchronizer runs regardless of `en`. Enabling while `sig_in` is already high gives no false edge.
- **FSM states:** IDLE and GATE.
  - IDLE → GATE when `en` = 1. On entry, the gate counter and edge counter clear to 0.
  - GATE → IDLE when `en` = 0. The window is aborted: no `freq_valid`, and `freq_cnt`/`freq_ovf` hold their previous values.
- **Gate window:**
  - In GATE, the gate counter increments once per cycle and rise increments the edge counter.
  - The edge counter saturates at 2^CNT_W−1 and sets a sticky window-overflow bit.
  - On the last window cycle (gate counter = GATE_CYCLES−1):
    - `freq_cnt` ← edge count, including a rise in that same cycle.
    - `freq_ovf` ← the overflow bit.
    - `freq_valid` pulses.
    - If `en` = 1, the counters clear and the next window starts on the following cycle. Windows are back-to-back with no dead cycle.
- **Gate counter width:** $clog2(GATE_CYCLES); it never exceeds GATE_CYCLES−1.
- **Period measurement:** active only while `en` = 1.
  - The run counter increments each cycle and saturates at 2^CNT_W−1.
  - On rise, the run counter is reset to 0.
  - On rise, if a previous edge has been seen since `en` rose: `period_cnt` ← run+1 (saturating), `period_ovf` ← (run saturated), and `period_valid` pulses.
  - The first rise after `en` rises, or after reset, only arms the measurement: no pulse.
  - When `en` = 0, the armed flag clears. `period_cnt` and `period_ovf` hold.
- **Input limit:** `sig_in` must stay high for ≥ 2 `clk` cycles and low for ≥ 2 `clk` cycles. Narrower pulses may be missed, and missing them is not an error.

## Timing
- **Reset:**
  - All outputs reset to 0.
  - FSM resets to IDLE.
  - s1, s2, s3, all counters and the armed flag reset to 0.
- **Edge latency:** if `sig_in` is first sampled high at edge k, rise is asserted during the cycle after edge k+1. Counters and registers reflect it at edge k+2.
- **Window start:** with `en` sampled 1 at edge e, `busy` = 1 from edge e.
- **Window end:** the window covers the GATE_CYCLES cycles following edge e. `freq_valid` and the new `freq_cnt` appear after edge e+GATE_CYCLES, both registered.
- **Period update:** `period_valid` and `period_cnt` update at the same edge that registers the rise.
- **Same-cycle events:**
  - A window end and a period update in the same cycle are both reported.
  - `rst` has priority over everything.
  - `en` falling on the last window cycle aborts the window: no `freq_valid`.
- **Outputs:** all registered; no combinational paths from inputs to outputs.

## Test plan
- **Nominal:** GATE_CYCLES=1000, `sig_in` period 25 clk (high 12, low 13), `en`=1 → each `freq_valid` reports `freq_cnt`=40, `freq_ovf`=0. `period_cnt`=25 on every `period_valid` after the first edge.
- **First edge:** `en` 0→1 with `sig_in` held high → no rise and no `period_valid` until the next 0→1 of `sig_in`. First `period_valid` comes at the second rise.
- **Abort:** drop `en` at window cycle 500 → `busy`=0 on the next cycle, no `freq_valid`, `freq_cnt` keeps the previous value (40). Re-raising `en` starts a full 1000-cycle window.
- **Overflow:** CNT_W=4, GATE_CYCLES=100, `sig_in` period 4 → `freq_cnt`=15, `freq_ovf`=1. Hold `sig_in` low 40 cycles, then add an edge → `period_cnt`=15, `period_ovf`=1.
- **Boundary edge:** place the synchronized rise exactly on window cycle GATE_CYCLES−1 → the edge is counted in the closing window, the next window starts at 0, and both `freq_valid` and `period_valid` pulse together.
- **Mid-window reset:** assert `rst` mid-window → every output is 0 on the next cycle, FSM is IDLE, and the first window after release reports the full expected count (40).
